// File: rtl/pwls_cmd_bridge.sv
// ============================================================================
// Module   : pwls_cmd_bridge
// Brief    : Ready/valid command stream to PWL peripheral register protocol
//            bridge, with read responses, burst auto-increment and an optional
//            read timeout enabled by `define PWLS_CMD_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwls_cmd_bridge #(
    parameter int DATA_BITS      = 13,
    parameter int ADDR_BITS      = 6,
    parameter int REG_SHIFT      = 3,
    parameter int ADDR_STEP      = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd,
    input  logic [DATA_BITS-1:0]           cmd_data,
    output logic [ADDR_BITS-1:0]           address,
    output logic [DATA_BITS+REG_SHIFT-1:0] data_in,
    output logic [1:0]                     data_write_n,
    output logic [1:0]                     data_read_n,
    input  logic [DATA_BITS+REG_SHIFT-1:0] data_out,
    input  logic                           data_ready,
    output logic                           rsp_valid,
    output logic [DATA_BITS-1:0]           rsp_data,
    output logic                           rsp_err
);

    localparam int c_DW = DATA_BITS + REG_SHIFT;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WSTB  = 2'd1;
    localparam logic [1:0] c_RWAIT = 2'd2;

    localparam logic [2:0] c_CMD_SET_ADDR       = 3'd1;
    localparam logic [2:0] c_CMD_SET_DATA       = 3'd2;
    localparam logic [2:0] c_CMD_WRITE          = 3'd3;
    localparam logic [2:0] c_CMD_READ           = 3'd4;
    localparam logic [2:0] c_CMD_WRITE_INC      = 3'd5;
    localparam logic [2:0] c_CMD_READ_INC       = 3'd6;
    localparam logic [2:0] c_CMD_DATA_WRITE_INC = 3'd7;

    localparam logic [ADDR_BITS-1:0] c_ADDR_STEP = ADDR_BITS'(ADDR_STEP);

    logic [1:0]           r_state;
    logic                 r_cmd_ready;
    logic                 r_inc;
    logic [ADDR_BITS-1:0] r_address;
    logic [DATA_BITS-1:0] r_data_reg;
    logic [1:0]           r_write_n;
    logic [1:0]           r_read_n;
    logic                 r_rsp_valid;
    logic [DATA_BITS-1:0] r_rsp_data;

    logic w_accept;
    logic w_rd_done;
    logic w_rd_timeout;

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_rd_done = (r_state == c_RWAIT) && data_ready;

`ifdef PWLS_CMD_BRIDGE_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_rsp_err;

    // data_ready on the last allowed cycle takes priority over the timeout
    assign w_rd_timeout = (r_state == c_RWAIT) && !data_ready && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_rd_timeout;
            if (r_state != c_RWAIT)
                r_to_cnt <= '0;
            else if (!data_ready && !w_rd_timeout)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_rd_timeout = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cmd_ready <= 1'b1;
            r_inc       <= 1'b0;
            r_address   <= '0;
            r_data_reg  <= '0;
            r_write_n   <= 2'b11;
            r_read_n    <= 2'b11;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        case (cmd)
                            c_CMD_SET_ADDR: r_address  <= cmd_data[ADDR_BITS-1:0];
                            c_CMD_SET_DATA: r_data_reg <= cmd_data;
                            c_CMD_WRITE, c_CMD_WRITE_INC, c_CMD_DATA_WRITE_INC: begin
                                if (cmd == c_CMD_DATA_WRITE_INC)
                                    r_data_reg <= cmd_data;
                                r_inc       <= (cmd != c_CMD_WRITE);
                                r_state     <= c_WSTB;
                                r_write_n   <= 2'b10;
                                r_cmd_ready <= 1'b0;
                            end
                            c_CMD_READ, c_CMD_READ_INC: begin
                                r_inc       <= (cmd == c_CMD_READ_INC);
                                r_state     <= c_RWAIT;
                                r_read_n    <= 2'b10;
                                r_cmd_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                c_WSTB: begin
                    r_state     <= c_IDLE;
                    r_write_n   <= 2'b11;
                    r_cmd_ready <= 1'b1;
                    if (r_inc)
                        r_address <= r_address + c_ADDR_STEP;
                end
                c_RWAIT: begin
                    if (w_rd_done || w_rd_timeout) begin
                        r_state     <= c_IDLE;
                        r_read_n    <= 2'b11;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rd_done ? data_out[c_DW-1:REG_SHIFT] : '1;
                        if (r_inc)
                            r_address <= r_address + c_ADDR_STEP;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_write_n   <= 2'b11;
                    r_read_n    <= 2'b11;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Low data_out bits sit below the register shift and carry no payload
    generate
        if (REG_SHIFT > 0) begin : g_low_bits
            logic w_unused_low;
            assign w_unused_low = ^data_out[REG_SHIFT-1:0];
        end
    endgenerate

    assign cmd_ready    = r_cmd_ready;
    assign address      = r_address;
    assign data_in      = c_DW'(r_data_reg) << REG_SHIFT;
    assign data_write_n = r_write_n;
    assign data_read_n  = r_read_n;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_pwls_cmd_bridge.sv
// ============================================================================
// Module   : tb_pwls_cmd_bridge
// Brief    : Self-checking bench for pwls_cmd_bridge against a behavioural
//            model of address/data registers and protocol timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwls_cmd_bridge;

    localparam int DB   = 13;
    localparam int AB   = 6;
    localparam int RS   = 3;
    localparam int STEP = 1;
    localparam int TO   = 15;
    localparam int DW   = DB + RS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd = 3'd0;
    logic [DB-1:0] cmd_data = '0;
    logic [AB-1:0] address;
    logic [DW-1:0] data_in;
    logic [1:0]    data_write_n;
    logic [1:0]    data_read_n;
    logic [DW-1:0] data_out = '0;
    logic          data_ready = 1'b0;
    logic          rsp_valid;
    logic [DB-1:0] rsp_data;
    logic          rsp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int m_addr  = 0;
    int m_data  = 0;

    pwls_cmd_bridge #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .REG_SHIFT(RS),
        .ADDR_STEP(STEP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_data(cmd_data), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_addr(input int a);
        return (a + STEP) % (1 << AB);
    endfunction

    // Present one command and leave the bench in the cycle after acceptance
    task automatic send(input logic [2:0] c, input int d);
        int w;
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = DB'(d);
        w = 0;
        while (!cmd_ready && w < 50) begin
            step();
            w++;
        end
        if (!cmd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_ready_wait cmd_ready=%0b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_tests++;
        if (cmd_ready !== 1'b1 || address !== '0 || data_in !== '0) begin
            n_fail++;
            $display("FAIL reset_regs ready=%0b addr=%0h data_in=%0h required 1/0/0", cmd_ready, address, data_in);
        end
        n_tests++;
        if (data_write_n !== 2'b11 || data_read_n !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_strobes wr=%b rd=%b required 11/11", data_write_n, data_read_n);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp valid=%0b data=%0h err=%0b required 0/0/0", rsp_valid, rsp_data, rsp_err);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%0b required 1", cmd_ready);
        end
        m_addr = 0;
        m_data = 0;
    endtask

    task automatic test_write();
        int a, d, kind;
        for (int i = 0; i < 9; i++) begin
            a    = (i == 0) ? 5 : int'($urandom_range(0, (1 << AB) - 1));
            d    = (i == 0) ? 'h1ABC : int'($urandom_range(0, (1 << DB) - 1));
            kind = i % 3;
            send(3'd1, a); m_addr = a;
            send(3'd2, d); m_data = d;
            if (kind == 2) begin
                d = int'($urandom_range(0, (1 << DB) - 1));
                send(3'd7, d); m_data = d;
            end else begin
                send((kind == 0) ? 3'd3 : 3'd5, int'($urandom_range(0, (1 << DB) - 1)));
            end
            n_tests++;
            if (data_write_n !== 2'b10 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_strobe it=%0d wr=%b ready=%0b required 10/0", i, data_write_n, cmd_ready);
            end
            n_tests++;
            if (address !== AB'(m_addr) || data_in !== DW'(m_data << RS)) begin
                n_fail++;
                $display("FAIL write_bus it=%0d addr=%0h data_in=%0h required %0h/%0h", i, address, data_in, m_addr, DW'(m_data << RS));
            end
            if (kind != 0) m_addr = next_addr(m_addr);
            step();
            n_tests++;
            if (data_write_n !== 2'b11 || cmd_ready !== 1'b1 || address !== AB'(m_addr)) begin
                n_fail++;
                $display("FAIL write_end it=%0d wr=%b ready=%0b addr=%0h required 11/1/%0h", i, data_write_n, cmd_ready, address, m_addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] vals [3];
        int strobes, idx, last_cyc, gap_bad, bus_bad;
        vals[0] = 13'h11; vals[1] = 13'h22; vals[2] = 13'h33;
        strobes = 0; idx = 0; last_cyc = -10; gap_bad = 0; bus_bad = 0;
        send(3'd1, 62); m_addr = 62;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (data_write_n == 2'b10) begin
                if (strobes >= 3 || address !== AB'(m_addr) || data_in !== (DW'(vals[strobes]) << RS))
                    bus_bad++;
                if (strobes > 0 && cyc - last_cyc != 2) gap_bad++;
                if (cmd_ready) gap_bad++;
                last_cyc = cyc;
                strobes++;
                m_addr = next_addr(m_addr);
            end
            if (cmd_ready) begin
                if (idx < 3) begin
                    cmd_valid = 1'b1; cmd = 3'd7; cmd_data = vals[idx]; idx++;
                end else begin
                    cmd_valid = 1'b0; cmd = 3'd0;
                end
            end
            step();
        end
        m_data = 'h33;
        n_tests++;
        if (strobes != 3 || bus_bad != 0) begin
            n_fail++;
            $display("FAIL burst_strobes count=%0d bad_bus=%0d required 3/0", strobes, bus_bad);
        end
        n_tests++;
        if (gap_bad != 0) begin
            n_fail++;
            $display("FAIL burst_spacing bad=%0d required 0", gap_bad);
        end
        n_tests++;
        if (address !== AB'(m_addr) || m_addr != 1) begin
            n_fail++;
            $display("FAIL burst_final_addr got=%0h required 1", address);
        end
    endtask

    task automatic test_read(input int a, input int dout, input int delay, input bit inc);
        int low, got, expd;
        data_ready = 1'b0;
        data_out   = DW'(dout);
        send(3'd1, a); m_addr = a;
        send(inc ? 3'd6 : 3'd4, int'($urandom_range(0, (1 << DB) - 1)));
        low = 0; got = 0;
        for (int c = 1; c <= 40 && got == 0; c++) begin
            if (rsp_valid) got = c;
            else begin
                if (data_read_n == 2'b10) low++;
                if (c == delay) data_ready = 1'b1;
                step();
            end
        end
        if (inc) m_addr = next_addr(m_addr);
        expd = (dout >> RS) & ((1 << DB) - 1);
        n_tests++;
        if (got != delay + 1 || low != delay) begin
            n_fail++;
            $display("FAIL read_timing delay=%0d rsp_cycle=%0d strobe_cycles=%0d required %0d/%0d", delay, got, low, delay + 1, delay);
        end
        n_tests++;
        if (rsp_data !== DB'(expd) || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data got=%0h err=%0b required %0h/0", rsp_data, rsp_err, expd);
        end
        n_tests++;
        if (data_read_n !== 2'b11 || cmd_ready !== 1'b1 || address !== AB'(m_addr)) begin
            n_fail++;
            $display("FAIL read_end rd=%b ready=%0b addr=%0h required 11/1/%0h", data_read_n, cmd_ready, address, m_addr);
        end
        data_ready = 1'b0;
        step();
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== DB'(expd)) begin
            n_fail++;
            $display("FAIL read_pulse_hold valid=%0b data=%0h required 0/%0h", rsp_valid, rsp_data, expd);
        end
    endtask

    task automatic test_read_ready_high();
        int a, dout;
        for (int i = 0; i < 3; i++) begin
            a    = (i == 0) ? (1 << AB) - 1 : int'($urandom_range(0, (1 << AB) - 1));
            dout = int'($urandom_range(0, (1 << DW) - 1));
            data_out   = DW'(dout);
            data_ready = 1'b1;
            send(3'd1, a); m_addr = a;
            n_tests++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_idle_ignored rsp_valid=%0b required 0", rsp_valid);
            end
            send(3'd6, 0);
            n_tests++;
            if (data_read_n !== 2'b10 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_high_n1 rd=%b valid=%0b required 10/0", data_read_n, rsp_valid);
            end
            step();
            m_addr = next_addr(m_addr);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== DB'(dout >> RS) || address !== AB'(m_addr)) begin
                n_fail++;
                $display("FAIL ready_high_n2 valid=%0b data=%0h addr=%0h required 1/%0h/%0h", rsp_valid, rsp_data, address, DB'(dout >> RS), m_addr);
            end
            data_ready = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        data_ready = 1'b0;
        send(3'd1, int'($urandom_range(1, (1 << AB) - 1)));
        send(3'd4, 0);
        n_tests++;
        if (data_read_n !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_read_pre rd=%b required 10", data_read_n);
        end
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if (data_read_n !== 2'b11 || cmd_ready !== 1'b1 || address !== '0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_read_async rd=%b ready=%0b addr=%0h valid=%0b required 11/1/0/0", data_read_n, cmd_ready, address, rsp_valid);
        end
        step();
        reset = 1'b0;
        m_addr = 0; m_data = 0;
        data_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (rsp_valid !== 1'b0 || data_read_n !== 2'b11) bad++;
        end
        data_ready = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_read_after bad_cycles=%0d required 0", bad);
        end
        send(3'd2, int'($urandom_range(1, (1 << DB) - 1)));
        send(3'd3, 0);
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if (data_write_n !== 2'b11 || data_in !== '0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_write_async wr=%b data_in=%0h ready=%0b required 11/0/1", data_write_n, data_in, cmd_ready);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_timeout();
`ifdef PWLS_CMD_BRIDGE_TIMEOUT_EN
        int low, got;
        data_ready = 1'b0;
        send(3'd1, 9); m_addr = 9;
        send(3'd6, 0);
        low = 0; got = 0;
        for (int c = 1; c <= 60 && got == 0; c++) begin
            if (rsp_valid) got = c;
            else begin
                if (data_read_n == 2'b10) low++;
                step();
            end
        end
        m_addr = next_addr(m_addr);
        n_tests++;
        if (got != TO + 1 || low != TO) begin
            n_fail++;
            $display("FAIL timeout_timing rsp_cycle=%0d strobe_cycles=%0d required %0d/%0d", got, low, TO + 1, TO);
        end
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_data !== {DB{1'b1}} || address !== AB'(m_addr)) begin
            n_fail++;
            $display("FAIL timeout_rsp err=%0b data=%0h addr=%0h required 1/%0h/%0h", rsp_err, rsp_data, address, {DB{1'b1}}, m_addr);
        end
        step();
        test_read(int'($urandom_range(0, (1 << AB) - 1)), int'($urandom_range(0, (1 << DW) - 1)), TO, 1'b1);
`else
        int bad;
        data_ready = 1'b0;
        send(3'd1, 9); m_addr = 9;
        send(3'd4, 0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || data_read_n !== 2'b10 || rsp_err !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_timeout_wait bad_cycles=%0d required 0", bad);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        m_addr = 0; m_data = 0;
        n_tests++;
        if (cmd_ready !== 1'b1 || data_read_n !== 2'b11) begin
            n_fail++;
            $display("FAIL no_timeout_recover ready=%0b rd=%b required 1/11", cmd_ready, data_read_n);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_read(7, 'h5558, 3, 1'b0);
        for (int i = 0; i < 5; i++)
            test_read(int'($urandom_range(0, (1 << AB) - 1)), int'($urandom_range(0, (1 << DW) - 1)),
                      int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
        test_read_ready_high();
        test_reset_mid_op();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
